// File: rtl/syscall_unit_if.sv
// Bundle of the syscall_unit pipeline, data-memory and console signals.
// slave = the syscall engine, master = core / memory / console side.
interface syscall_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) ();
   logic              syscall_valid;
   logic [DATA_W-1:0] v0;
   logic [DATA_W-1:0] a0;
   logic              busy;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [7:0]        mem_rdata;
   logic              char_valid;
   logic [7:0]        char_data;
   logic              char_ready;
   logic              halt;
   logic              err;

   modport slave (
      input  syscall_valid, v0, a0, mem_ack, mem_rdata, char_ready,
      output busy, mem_req, mem_addr, char_valid, char_data, halt, err
   );

   modport master (
      output syscall_valid, v0, a0, mem_ack, mem_rdata, char_ready,
      input  busy, mem_req, mem_addr, char_valid, char_data, halt, err
   );
endinterface

// File: rtl/syscall_unit.sv
// Clocked syscall engine: print int / string / char, exit; streams ASCII to a console port.
// Define SYSCALL_HEX_EN to add v0=34 (print "0x" + zero-padded uppercase hex).
//
// state     | meaning
// IDLE      | waiting for a syscall
// CONV      | one decimal digit per cycle pushed onto the digit stack
// EMIT_SIGN | presenting '-' for a negative integer
// EMIT_DIG  | popping stack entries to the console, MSB first
// STR_REQ   | issuing a byte fetch at base + index
// STR_WAIT  | holding the fetch until mem_ack
// STR_EMIT  | presenting the fetched byte
// CHAR_EMIT | presenting a0[7:0]
// HALTED    | exit taken; sticky until reset
module syscall_unit #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MAX_STR   = 256,
   parameter int EXIT_CODE = 10
) (
   input logic           clk,
   input logic           rst,
   syscall_unit_if.slave bus
);
   localparam int DEC_D = (DATA_W * 30103 + 99999) / 100000 + 1;
   localparam int HEX_D = DATA_W / 4 + 2;
   localparam int STK_D = (DEC_D > HEX_D) ? DEC_D : HEX_D;
   localparam int SP_W  = $clog2(STK_D + 1);
   localparam int IDX_W = $clog2(MAX_STR + 1);

   typedef enum logic [3:0] {
      IDLE, CONV, EMIT_SIGN, EMIT_DIG, STR_REQ, STR_WAIT, STR_EMIT, CHAR_EMIT, HALTED
   } state_t;

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              char_valid_q, char_valid_d;
   logic [7:0]        char_data_q, char_data_d;
   logic              halt_q, halt_d;
   logic              err_q, err_d;
   logic              neg_q, neg_d;
   logic [DATA_W-1:0] mag_q, mag_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic [7:0]        stk_q [STK_D];
   logic [7:0]        stk_d [STK_D];

   logic [DATA_W-1:0] quo;
   logic [3:0]        dig;

   assign quo = mag_q / DATA_W'(10);
   assign dig = 4'(mag_q % DATA_W'(10));

`ifdef SYSCALL_HEX_EN
   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction
`endif

   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      char_valid_d = char_valid_q;
      char_data_d  = char_data_q;
      halt_d       = halt_q;
      err_d        = 1'b0;
      neg_d        = neg_q;
      mag_d        = mag_q;
      base_d       = base_q;
      idx_d        = idx_q;
      sp_d         = sp_q;
      stk_d        = stk_q;

      unique case (state_q)
         IDLE: begin
            if (bus.syscall_valid && !halt_q) begin
               if (bus.v0 == DATA_W'(1)) begin
                  neg_d   = bus.a0[DATA_W-1];
                  mag_d   = bus.a0[DATA_W-1] ? (~bus.a0 + DATA_W'(1)) : bus.a0;
                  sp_d    = '0;
                  state_d = CONV;
                  busy_d  = 1'b1;
               end else if (bus.v0 == DATA_W'(4)) begin
                  base_d  = ADDR_W'(bus.a0);
                  idx_d   = '0;
                  state_d = STR_REQ;
                  busy_d  = 1'b1;
               end else if (bus.v0 == DATA_W'(11)) begin
                  char_valid_d = 1'b1;
                  char_data_d  = bus.a0[7:0];
                  state_d      = CHAR_EMIT;
                  busy_d       = 1'b1;
               end else if (bus.v0 == DATA_W'(EXIT_CODE)) begin
                  halt_d  = 1'b1;
                  state_d = HALTED;
                  busy_d  = 1'b1;
`ifdef SYSCALL_HEX_EN
               end else if (bus.v0 == DATA_W'(34)) begin
                  // Load the whole string onto the stack at once; top of stack is the leading '0'.
                  for (int k = 0; k < DATA_W / 4; k++) stk_d[k] = hex_char(bus.a0[4*k +: 4]);
                  stk_d[DATA_W/4]     = 8'h78;
                  stk_d[DATA_W/4 + 1] = 8'h30;
                  sp_d    = SP_W'(HEX_D);
                  neg_d   = 1'b0;
                  state_d = EMIT_DIG;
                  busy_d  = 1'b1;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         CONV: begin
            stk_d[sp_q] = 8'h30 + {4'h0, dig};
            sp_d        = sp_q + SP_W'(1);
            mag_d       = quo;
            if (quo == '0) begin
               if (neg_q) begin
                  char_valid_d = 1'b1;
                  char_data_d  = 8'h2D;
                  state_d      = EMIT_SIGN;
               end else begin
                  state_d = EMIT_DIG;
               end
            end
         end
         EMIT_SIGN: begin
            if (bus.char_ready) begin
               char_valid_d = 1'b0;
               state_d      = EMIT_DIG;
            end
         end
         EMIT_DIG: begin
            if (!char_valid_q) begin
               char_valid_d = 1'b1;
               char_data_d  = stk_q[sp_q - SP_W'(1)];
               sp_d         = sp_q - SP_W'(1);
            end else if (bus.char_ready) begin
               char_valid_d = 1'b0;
               if (sp_q == '0) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         STR_REQ: begin
            mem_req_d  = 1'b1;
            mem_addr_d = base_q + ADDR_W'(idx_q);
            state_d    = STR_WAIT;
         end
         STR_WAIT: begin
            if (bus.mem_ack) begin
               mem_req_d = 1'b0;
               if (bus.mem_rdata == 8'h00) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  char_valid_d = 1'b1;
                  char_data_d  = bus.mem_rdata;
                  state_d      = STR_EMIT;
               end
            end
         end
         STR_EMIT: begin
            if (bus.char_ready) begin
               char_valid_d = 1'b0;
               idx_d        = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(MAX_STR - 1)) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = STR_REQ;
               end
            end
         end
         CHAR_EMIT: begin
            if (bus.char_ready) begin
               char_valid_d = 1'b0;
               state_d      = IDLE;
               busy_d       = 1'b0;
            end
         end
         HALTED: begin
            halt_d = 1'b1;
            busy_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         char_valid_q <= 1'b0;
         char_data_q  <= '0;
         halt_q       <= 1'b0;
         err_q        <= 1'b0;
         neg_q        <= 1'b0;
         mag_q        <= '0;
         base_q       <= '0;
         idx_q        <= '0;
         sp_q         <= '0;
         stk_q        <= '{default: '0};
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         char_valid_q <= char_valid_d;
         char_data_q  <= char_data_d;
         halt_q       <= halt_d;
         err_q        <= err_d;
         neg_q        <= neg_d;
         mag_q        <= mag_d;
         base_q       <= base_d;
         idx_q        <= idx_d;
         sp_q         <= sp_d;
         stk_q        <= stk_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.char_valid = char_valid_q;
   assign bus.char_data  = char_data_q;
   assign bus.halt       = halt_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_syscall_unit.sv
// Randomised self-checking bench for syscall_unit; expected text comes from $sformatf and a byte-array memory.
module tb_syscall_unit;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 32;
   localparam int MAX_STR   = 4;
   localparam int EXIT_CODE = 10;
   localparam int LIMIT     = 3000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   syscall_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   syscall_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_STR(MAX_STR), .EXIT_CODE(EXIT_CODE))
      dut (.clk(clk), .rst(rst), .bus(bus));

   int asserts = 0;
   int fails   = 0;

   logic [7:0]  mem [logic [31:0]];
   logic [7:0]  got_q [$];
   logic [31:0] addr_q [$];
   int          err_cycles = 0;
   int          stab_err = 0;
   bit          rdy_rand = 1'b1;
   bit          rdy_force = 1'b0;
   bit          hold_prev = 1'b0;
   logic [7:0]  data_prev = 8'h00;
   bit          pend = 1'b0;
   int          wcnt = 0;

   // memory responder: random 0..3 cycle ack latency
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         bus.mem_ack = 1'b0;
         if (bus.mem_req === 1'b1 && rst === 1'b0) begin
            if (!pend) begin
               pend = 1'b1;
               wcnt = $urandom_range(0, 3);
            end
            if (wcnt == 0) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 8'h00;
               addr_q.push_back(bus.mem_addr);
               pend = 1'b0;
            end else begin
               wcnt--;
            end
         end else begin
            pend = 1'b0;
         end
      end
   end

   // console sink and monitor
   initial begin
      bus.char_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (hold_prev && (bus.char_valid !== 1'b1 || bus.char_data !== data_prev)) stab_err++;
         bus.char_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
         #1;
         if (rst === 1'b0 && bus.char_valid === 1'b1 && bus.char_ready === 1'b1)
            got_q.push_back(bus.char_data);
         if (bus.err === 1'b1) err_cycles++;
         hold_prev = (rst === 1'b0) && bus.char_valid === 1'b1 && bus.char_ready === 1'b0;
         data_prev = bus.char_data;
      end
   end

   function automatic string q2s();
      string s = "";
      foreach (got_q[i]) s = $sformatf("%s%c", s, got_q[i]);
      return s;
   endfunction

   // caller sits at a negedge; returns at the negedge after the accepting edge
   task automatic issue(input logic [31:0] v, input logic [31:0] a);
      int n = 0;
      bus.syscall_valid = 1'b1;
      bus.v0 = v;
      bus.a0 = a;
      while (bus.busy !== 1'b0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      asserts++;
      if (n >= LIMIT) begin
         fails++;
         $display("FAIL accept_timeout v0=%0d: busy stayed %b, required 0", v, bus.busy);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy !== 1'b0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      asserts++;
      if (n >= LIMIT) begin
         fails++;
         $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_int(input logic [31:0] a);
      string exp, got;
      got_q.delete();
      err_cycles = 0;
      issue(32'd1, a);
      bus.syscall_valid = 1'b0;
      wait_idle();
      exp = $sformatf("%0d", $signed(a));
      got = q2s();
      asserts++;
      if (got != exp || err_cycles != 0) begin
         fails++;
         $display("FAIL print_int a0=%h: got \"%s\" err=%0d, required \"%s\" err=0", a, got, err_cycles, exp);
      end
   endtask

   task automatic run_str(input logic [31:0] base, input int len);
      string       exp = "";
      logic [31:0] exp_a [$];
      logic [7:0]  b;
      bit          bad = 1'b0;
      mem.delete();
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom_range(1, 255));
         mem[base + 32'(i)] = b;
         if (i < MAX_STR) exp = $sformatf("%s%c", exp, b);
      end
      mem[base + 32'(len)] = 8'h00;
      for (int i = 0; i < ((len < MAX_STR) ? len + 1 : MAX_STR); i++) exp_a.push_back(base + 32'(i));
      got_q.delete();
      addr_q.delete();
      issue(32'd4, base);
      bus.syscall_valid = 1'b0;
      wait_idle();
      if (addr_q.size() != exp_a.size()) bad = 1'b1;
      else foreach (exp_a[i]) if (addr_q[i] !== exp_a[i]) bad = 1'b1;
      asserts++;
      if (q2s() != exp || bad) begin
         fails++;
         $display("FAIL print_str base=%h len=%0d: got \"%s\" with %0d fetches (first %h), required \"%s\" with %0d fetches from %h",
                  base, len, q2s(), addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 32'h0, exp, exp_a.size(), base);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.syscall_valid = 1'b0;
      bus.v0 = '0;
      bus.a0 = '0;
      repeat (3) @(negedge clk);
      asserts++;
      if ({bus.busy, bus.mem_req, bus.char_valid, bus.halt, bus.err} !== 5'b0) begin
         fails++;
         $display("FAIL reset_ctrl: busy/req/valid/halt/err=%b, required 00000",
                  {bus.busy, bus.mem_req, bus.char_valid, bus.halt, bus.err});
      end
      asserts++;
      if (bus.mem_addr !== 32'h0 || bus.char_data !== 8'h00) begin
         fails++;
         $display("FAIL reset_data: mem_addr=%h char_data=%h, required 0", bus.mem_addr, bus.char_data);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_print_int();
      run_int(32'd42);
      run_int(32'd0);
      run_int(32'h8000_0000);
      run_int(32'hFFFF_FFF9);
      run_int(32'h7FFF_FFFF);
      run_int(32'd9);
      run_int(32'd10);
      for (int i = 0; i < 12; i++) run_int($urandom);
   endtask

   task automatic test_print_str();
      bit bad = 1'b0;
      mem.delete();
      mem[32'h100] = 8'h48;
      mem[32'h101] = 8'h69;
      mem[32'h102] = 8'h00;
      got_q.delete();
      addr_q.delete();
      issue(32'd4, 32'h100);
      bus.syscall_valid = 1'b0;
      wait_idle();
      if (addr_q.size() != 3) bad = 1'b1;
      else if (addr_q[0] !== 32'h100 || addr_q[1] !== 32'h101 || addr_q[2] !== 32'h102) bad = 1'b1;
      asserts++;
      if (q2s() != "Hi" || bad) begin
         fails++;
         $display("FAIL str_hi: got \"%s\" with %0d fetches, required \"Hi\" with fetches 100,101,102",
                  q2s(), addr_q.size());
      end
      run_str(32'h0000_1000, 10);
      run_str(32'hFFFF_FFFE, 5);
      run_str(32'h0000_2000, 0);
      run_str(32'h0000_3000, MAX_STR - 1);
      run_str(32'h0000_4000, MAX_STR);
      for (int i = 0; i < 6; i++) run_str($urandom, $urandom_range(0, 7));
   endtask

   task automatic test_char_backpressure();
      int bad = 0;
      rdy_rand  = 1'b0;
      rdy_force = 1'b0;
      repeat (2) @(negedge clk);
      got_q.delete();
      issue(32'd11, 32'h0000_0041);
      bus.syscall_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (bus.char_valid !== 1'b1 || bus.char_data !== 8'h41) bad++;
         @(negedge clk);
      end
      asserts++;
      if (bad != 0) begin
         fails++;
         $display("FAIL char_hold: %0d cycles without valid=1 data=41 (last valid=%b data=%h), required 0",
                  bad, bus.char_valid, bus.char_data);
      end
      rdy_force = 1'b1;
      wait_idle();
      asserts++;
      if (got_q.size() != 1 || got_q[0] !== 8'h41) begin
         fails++;
         $display("FAIL char_xfer: got %0d chars (first %h), required 1 char 41",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
      end
      rdy_rand = 1'b1;
      got_q.delete();
      issue(32'd11, 32'hABCD_EF00);
      bus.syscall_valid = 1'b0;
      wait_idle();
      asserts++;
      if (got_q.size() != 1 || got_q[0] !== 8'h00) begin
         fails++;
         $display("FAIL char_nul: got %0d chars (first %h), required 1 char 00",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hFF);
      end
   endtask

   task automatic test_unknown();
      logic [31:0] bad_v [5] = '{32'd7, 32'd0, 32'd2, 32'd12, 32'hFFFF_FFFF};
      foreach (bad_v[i]) begin
         got_q.delete();
         err_cycles = 0;
         issue(bad_v[i], $urandom);
         bus.syscall_valid = 1'b0;
         repeat (3) @(negedge clk);
         asserts++;
         if (err_cycles != 1 || got_q.size() != 0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL unknown v0=%0d: err cycles=%0d chars=%0d busy=%b, required 1/0/0",
                     bad_v[i], err_cycles, got_q.size(), bus.busy);
         end
      end
   endtask

   task automatic test_hex();
      logic [31:0] vals [3];
      vals[0] = 32'h0000_BEEF;
      vals[1] = $urandom;
      vals[2] = 32'hF00D_0001;
      foreach (vals[i]) begin
         got_q.delete();
         err_cycles = 0;
         issue(32'd34, vals[i]);
         bus.syscall_valid = 1'b0;
         wait_idle();
`ifdef SYSCALL_HEX_EN
         asserts++;
         if (q2s() != $sformatf("0x%08X", vals[i]) || err_cycles != 0) begin
            fails++;
            $display("FAIL hex a0=%h: got \"%s\" err=%0d, required \"0x%08X\" err=0", vals[i], q2s(), err_cycles, vals[i]);
         end
`else
         asserts++;
         if (err_cycles != 1 || got_q.size() != 0) begin
            fails++;
            $display("FAIL hex_disabled a0=%h: err cycles=%0d chars=%0d, required 1/0", vals[i], err_cycles, got_q.size());
         end
`endif
      end
   endtask

   task automatic test_back_to_back();
      string exp = "";
      int    n_err = 0;
      int    kind;
      logic [31:0] a;
      got_q.delete();
      err_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         kind = $urandom_range(0, 2);
         a = $urandom;
         if (kind == 0) begin
            a[7:0] = 8'($urandom_range(33, 126));
            issue(32'd11, a);
            exp = $sformatf("%s%c", exp, a[7:0]);
         end else if (kind == 1) begin
            issue(32'd1, a);
            exp = $sformatf("%s%0d", exp, $signed(a));
         end else begin
            issue(32'd5, a);
            n_err++;
         end
      end
      bus.syscall_valid = 1'b0;
      wait_idle();
      asserts++;
      if (q2s() != exp || err_cycles != n_err) begin
         fails++;
         $display("FAIL back_to_back: got \"%s\" err=%0d, required \"%s\" err=%0d", q2s(), err_cycles, exp, n_err);
      end
   endtask

   task automatic test_halt();
      bit seen = 1'b0;
      issue(32'(EXIT_CODE), 32'd0);
      bus.syscall_valid = 1'b0;
      repeat (2) @(negedge clk);
      asserts++;
      if (bus.halt !== 1'b1 || bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL halt_set: halt=%b busy=%b, required 1/1", bus.halt, bus.busy);
      end
      got_q.delete();
      bus.syscall_valid = 1'b1;
      bus.v0 = 32'd1;
      bus.a0 = 32'd5;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.char_valid === 1'b1 || bus.mem_req === 1'b1) seen = 1'b1;
         if (i == 6) bus.v0 = 32'd4;
      end
      bus.syscall_valid = 1'b0;
      asserts++;
      if (seen || got_q.size() != 0 || bus.halt !== 1'b1 || bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL halt_sticky: activity=%b chars=%0d halt=%b busy=%b, required 0/0/1/1",
                  seen, got_q.size(), bus.halt, bus.busy);
      end
      apply_reset();
      asserts++;
      if (bus.halt !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL halt_clear: halt=%b busy=%b, required 0/0", bus.halt, bus.busy);
      end
   endtask

   task automatic test_reset_mid_string();
      int n = 0;
      bit seen = 1'b0;
      mem.delete();
      for (int i = 0; i < 8; i++) mem[32'h200 + 32'(i)] = 8'h41 + 8'(i);
      mem[32'h208] = 8'h00;
      got_q.delete();
      issue(32'd4, 32'h200);
      bus.syscall_valid = 1'b0;
      while (got_q.size() == 0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      asserts++;
      if ({bus.busy, bus.mem_req, bus.char_valid, bus.halt, bus.err} !== 5'b0 ||
          bus.mem_addr !== 32'h0 || bus.char_data !== 8'h00) begin
         fails++;
         $display("FAIL mid_reset_outputs: busy/req/valid/halt/err=%b addr=%h data=%h, required all 0",
                  {bus.busy, bus.mem_req, bus.char_valid, bus.halt, bus.err}, bus.mem_addr, bus.char_data);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.mem_req === 1'b1 || bus.char_valid === 1'b1) seen = 1'b1;
      end
      asserts++;
      if (seen || got_q.size() != 1 || n >= LIMIT) begin
         fails++;
         $display("FAIL mid_reset_quiet: activity=%b chars=%0d wait=%0d, required 0 activity and exactly 1 char",
                  seen, got_q.size(), n);
      end
   endtask

   initial begin
      test_reset();
      test_print_int();
      test_print_str();
      test_char_backpressure();
      test_unknown();
      test_hex();
      test_back_to_back();
      test_reset_mid_string();
      test_halt();
      asserts++;
      if (stab_err != 0) begin
         fails++;
         $display("FAIL char_stable: %0d stalled cycles changed valid/data, required 0", stab_err);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
